// File: rtl/branch_pkg.sv
// Shared widths, entry/issue struct types and the CDB wakeup helper
// for the branch reservation station.
package branch_pkg;

    localparam int B_WIDTH   = 31;  // data/address MSB index
    localparam int B_C_WIDTH = 7;   // {isJAL,isJALR,funct3,state[1:0],redirect} MSB index
    localparam int B_T_WIDTH = 3;   // ROB/CDB tag MSB index
    localparam int B_DEPTH   = 4;   // number of entries

    typedef struct packed {
        logic                 valid;
        logic                 rdy1;
        logic [B_T_WIDTH:0]   tag1;
        logic [B_WIDTH:0]     val1;
        logic                 rdy2;
        logic [B_T_WIDTH:0]   tag2;
        logic [B_WIDTH:0]     val2;
        logic [B_WIDTH:0]     pred_pc;
        logic [B_WIDTH:0]     target;
        logic [B_C_WIDTH:0]   ctrl;
        logic [B_T_WIDTH:0]   rob_tag;
    } rs_entry_t;

    typedef struct packed {
        logic [B_WIDTH:0]     src1;
        logic [B_WIDTH:0]     src2;
        logic [B_WIDTH:0]     pred_pc;
        logic [B_WIDTH:0]     target;
        logic [B_C_WIDTH:0]   ctrl;
        logic [B_T_WIDTH:0]   rob_tag;
    } issue_t;

    // Apply a CDB broadcast to one entry; both operands may wake together.
    function automatic rs_entry_t wake_entry(input rs_entry_t e,
                                             input logic cdb_valid,
                                             input logic [B_T_WIDTH:0] cdb_tag,
                                             input logic [B_WIDTH:0] cdb_result);
        rs_entry_t r;
        r = e;
        if (e.valid && cdb_valid) begin
            if (!e.rdy1 && e.tag1 == cdb_tag) begin
                r.rdy1 = 1'b1;
                r.val1 = cdb_result;
            end
            if (!e.rdy2 && e.tag2 == cdb_tag) begin
                r.rdy2 = 1'b1;
                r.val2 = cdb_result;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first select: slot 0 is oldest, so grant the lowest set bit.
module rs_age_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] eligible,
    output logic [N-1:0] grant,
    output logic         any_valid
);

    // Priority encode toward index 0
    always_comb begin
        logic taken;
        grant = '0;
        taken = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
    end

    assign any_valid = |eligible;

endmodule

// File: rtl/branch_res_station.sv
// Branch reservation station: compacting age queue with CDB snooping,
// oldest-ready issue and synchronous flush.
module branch_res_station
    import branch_pkg::*;
#(
    parameter int WIDTH   = B_WIDTH,
    parameter int C_WIDTH = B_C_WIDTH,
    parameter int T_WIDTH = B_T_WIDTH,
    parameter int DEPTH   = B_DEPTH
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             flush,
    input  logic             dispatchValid,
    input  logic [WIDTH:0]   dispatchSrc1,
    input  logic [WIDTH:0]   dispatchSrc2,
    input  logic             dispatchRdy1,
    input  logic             dispatchRdy2,
    input  logic [T_WIDTH:0] dispatchTag1,
    input  logic [T_WIDTH:0] dispatchTag2,
    input  logic [WIDTH:0]   dispatchPredPC,
    input  logic [WIDTH:0]   dispatchTarget,
    input  logic [C_WIDTH:0] dispatchCtrl,
    input  logic [T_WIDTH:0] dispatchRobTag,
    input  logic             cdbValid,
    input  logic [T_WIDTH:0] cdbTag,
    input  logic [WIDTH:0]   cdbResult,
    output logic             issueValid,
    input  logic             issueReady,
    output logic [WIDTH:0]   src1,
    output logic [WIDTH:0]   src2,
    output logic [WIDTH:0]   predictedPC,
    output logic [WIDTH:0]   targetAddress,
    output logic [C_WIDTH:0] branchControl,
    output logic [T_WIDTH:0] issueRobTag,
    output logic             full
);

    localparam int CW = $clog2(DEPTH + 1);

    rs_entry_t        q     [DEPTH];
    rs_entry_t        nq    [DEPTH];
    rs_entry_t        woke  [DEPTH];
    rs_entry_t        new_e;
    logic [CW-1:0]    count, count_nxt, wr_idx;
    logic [DEPTH-1:0] elig, grant;
    logic             any_elig, fire, dispatch;
    issue_t           sel;

    // Eligibility uses registered readiness only, so a wakeup counts next cycle
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            elig[i] = q[i].valid & q[i].rdy1 & q[i].rdy2;
    end

    rs_age_select #(.N(DEPTH)) u_age_select (
        .eligible  (elig),
        .grant     (grant),
        .any_valid (any_elig)
    );

    // One-hot mux of the granted entry; all zeros when nothing is granted
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel.src1    = q[i].val1;
                sel.src2    = q[i].val2;
                sel.pred_pc = q[i].pred_pc;
                sel.target  = q[i].target;
                sel.ctrl    = q[i].ctrl;
                sel.rob_tag = q[i].rob_tag;
            end
        end
    end

    assign issueValid    = any_elig;
    assign src1          = sel.src1;
    assign src2          = sel.src2;
    assign predictedPC   = sel.pred_pc;
    assign targetAddress = sel.target;
    assign branchControl = sel.ctrl;
    assign issueRobTag   = sel.rob_tag;

    assign full     = (count == CW'(DEPTH));
    assign fire     = any_elig & issueReady;
    assign dispatch = dispatchValid & ~full & ~flush;
    // Issue removes one slot below the tail, so the new entry lands one lower
    assign wr_idx   = count - CW'(fire);

    // Build the incoming entry, capturing a same-cycle CDB result
    always_comb begin
        new_e         = '0;
        new_e.valid   = 1'b1;
        new_e.rdy1    = dispatchRdy1;
        new_e.tag1    = dispatchTag1;
        new_e.val1    = dispatchSrc1;
        new_e.rdy2    = dispatchRdy2;
        new_e.tag2    = dispatchTag2;
        new_e.val2    = dispatchSrc2;
        new_e.pred_pc = dispatchPredPC;
        new_e.target  = dispatchTarget;
        new_e.ctrl    = dispatchCtrl;
        new_e.rob_tag = dispatchRobTag;
        new_e         = wake_entry(new_e, cdbValid, cdbTag, cdbResult);
    end

    // Next queue: wake, compact over the issued slot, append, then flush wins
    always_comb begin
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            woke[i] = wake_entry(q[i], cdbValid, cdbTag, cdbResult);
        for (int i = 0; i < DEPTH - 1; i++) begin
            seen  = seen | grant[i];
            nq[i] = (fire && seen) ? woke[i+1] : woke[i];
        end
        nq[DEPTH-1] = fire ? '0 : woke[DEPTH-1];
        for (int i = 0; i < DEPTH; i++)
            if (dispatch && int'(wr_idx) == i)
                nq[i] = new_e;
        count_nxt = count + CW'(dispatch) - CW'(fire);
        if (flush) begin
            for (int i = 0; i < DEPTH; i++)
                nq[i] = '0;
            count_nxt = '0;
        end
    end

    // Queue and occupancy registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++)
                q[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                q[i] <= nq[i];
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_branch_res_station.sv
// Directed self-checking bench for branch_res_station.
module tb_branch_res_station;

    logic        clk = 1'b0;
    logic        resetN, flush;
    logic        dispatchValid, dispatchRdy1, dispatchRdy2;
    logic [31:0] dispatchSrc1, dispatchSrc2, dispatchPredPC, dispatchTarget;
    logic [3:0]  dispatchTag1, dispatchTag2, dispatchRobTag;
    logic [7:0]  dispatchCtrl;
    logic        cdbValid;
    logic [3:0]  cdbTag;
    logic [31:0] cdbResult;
    logic        issueValid, issueReady, full;
    logic [31:0] src1, src2, predictedPC, targetAddress;
    logic [7:0]  branchControl;
    logic [3:0]  issueRobTag;

    int total = 0;
    int fails = 0;

    localparam logic [7:0] BEQ = 8'b0000_0010;

    branch_res_station dut (
        .clk(clk), .resetN(resetN), .flush(flush),
        .dispatchValid(dispatchValid), .dispatchSrc1(dispatchSrc1), .dispatchSrc2(dispatchSrc2),
        .dispatchRdy1(dispatchRdy1), .dispatchRdy2(dispatchRdy2),
        .dispatchTag1(dispatchTag1), .dispatchTag2(dispatchTag2),
        .dispatchPredPC(dispatchPredPC), .dispatchTarget(dispatchTarget),
        .dispatchCtrl(dispatchCtrl), .dispatchRobTag(dispatchRobTag),
        .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbResult(cdbResult),
        .issueValid(issueValid), .issueReady(issueReady),
        .src1(src1), .src2(src2), .predictedPC(predictedPC), .targetAddress(targetAddress),
        .branchControl(branchControl), .issueRobTag(issueRobTag), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [31:0] s1, input logic r1, input logic [3:0] t1,
                        input logic [31:0] s2, input logic r2, input logic [3:0] t2,
                        input logic [3:0] rob);
        dispatchValid = 1'b1;
        dispatchSrc1 = s1; dispatchRdy1 = r1; dispatchTag1 = t1;
        dispatchSrc2 = s2; dispatchRdy2 = r2; dispatchTag2 = t2;
        dispatchRobTag = rob;
    endtask

    task automatic idle();
        dispatchValid = 1'b0;
        cdbValid      = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; flush = 1'b0; issueReady = 1'b0;
        dispatchValid = 1'b0; dispatchRdy1 = 1'b0; dispatchRdy2 = 1'b0;
        dispatchSrc1 = '0; dispatchSrc2 = '0; dispatchTag1 = '0; dispatchTag2 = '0;
        dispatchPredPC = '0; dispatchTarget = '0; dispatchCtrl = '0; dispatchRobTag = '0;
        cdbValid = 1'b0; cdbTag = '0; cdbResult = '0;
        #12;
        chk("reset_issueValid", {31'b0, issueValid}, 32'd0);
        chk("reset_full", {31'b0, full}, 32'd0);
        chk("reset_src1", src1, 32'd0);
        resetN = 1'b1;
        step();

        // Single ready branch issues the cycle after dispatch
        disp(32'd5, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 4'd9);
        dispatchCtrl = BEQ; dispatchPredPC = 32'h100; dispatchTarget = 32'h200;
        issueReady = 1'b1;
        chk("basic_not_yet", {31'b0, issueValid}, 32'd0);
        step();
        idle();
        chk("basic_valid", {31'b0, issueValid}, 32'd1);
        chk("basic_src1", src1, 32'd5);
        chk("basic_src2", src2, 32'd5);
        chk("basic_ctrl", {24'b0, branchControl}, {24'b0, BEQ});
        chk("basic_pred", predictedPC, 32'h100);
        chk("basic_target", targetAddress, 32'h200);
        chk("basic_rob", {28'b0, issueRobTag}, 32'd9);
        step();
        chk("basic_empty", {31'b0, issueValid}, 32'd0);
        chk("basic_count", 32'(dut.count), 32'd0);
        chk("idle_outputs_zero", predictedPC, 32'd0);

        // Younger ready entry bypasses older waiting one; older wakes via CDB
        issueReady = 1'b0;
        disp(32'd0, 1'b0, 4'd3, 32'd7, 1'b1, 4'd0, 4'd1);
        step();
        disp(32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd2);
        step();
        idle();
        issueReady = 1'b1;
        cdbValid = 1'b1; cdbTag = 4'd3; cdbResult = 32'h10;
        chk("wake_B_first_valid", {31'b0, issueValid}, 32'd1);
        chk("wake_B_first_rob", {28'b0, issueRobTag}, 32'd2);
        step();
        cdbValid = 1'b0;
        chk("wake_A_valid", {31'b0, issueValid}, 32'd1);
        chk("wake_A_rob", {28'b0, issueRobTag}, 32'd1);
        chk("wake_A_src1", src1, 32'h10);
        chk("wake_A_src2", src2, 32'd7);
        step();
        chk("wake_count", 32'(dut.count), 32'd0);

        // Fill, then a dispatch while full is dropped even with issue firing
        issueReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(32'(i), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'(4 + i));
            step();
        end
        idle();
        chk("fill_full", {31'b0, full}, 32'd1);
        chk("fill_count", 32'(dut.count), 32'd4);
        disp(32'd99, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd8);
        issueReady = 1'b1;
        chk("fill_oldest_rob", {28'b0, issueRobTag}, 32'd4);
        step();
        idle();
        chk("drop_count", 32'(dut.count), 32'd3);
        chk("drop_full", {31'b0, full}, 32'd0);
        chk("drain_rob5", {28'b0, issueRobTag}, 32'd5);
        step();
        chk("drain_rob6", {28'b0, issueRobTag}, 32'd6);
        step();
        chk("drain_rob7", {28'b0, issueRobTag}, 32'd7);
        step();
        chk("drain_count", 32'(dut.count), 32'd0);

        // Same-cycle CDB capture at dispatch
        issueReady = 1'b0;
        disp(32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd7, 4'd3);
        cdbValid = 1'b1; cdbTag = 4'd7; cdbResult = 32'hABCD;
        step();
        idle();
        chk("capture_valid", {31'b0, issueValid}, 32'd1);
        chk("capture_src2", src2, 32'hABCD);
        issueReady = 1'b1;
        step();
        chk("capture_count", 32'(dut.count), 32'd0);

        // Flush overrides dispatch and issue
        issueReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'(10 + i));
            step();
        end
        chk("preflush_count", 32'(dut.count), 32'd3);
        disp(32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd13);
        flush = 1'b1; issueReady = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("flush_count", 32'(dut.count), 32'd0);
        chk("flush_issueValid", {31'b0, issueValid}, 32'd0);
        chk("flush_rob_zero", {28'b0, issueRobTag}, 32'd0);

        // Async reset pulse between edges discards held entries
        issueReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            disp(32'h55, 1'b1, 4'd0, 32'h66, 1'b1, 4'd0, 4'(1 + i));
            step();
        end
        idle();
        chk("prereset_valid", {31'b0, issueValid}, 32'd1);
        #1 resetN = 1'b0;
        #1;
        chk("async_issueValid", {31'b0, issueValid}, 32'd0);
        chk("async_src1", src1, 32'd0);
        chk("async_count", 32'(dut.count), 32'd0);
        resetN = 1'b1;
        issueReady = 1'b1;
        step();
        chk("postreset_issueValid", {31'b0, issueValid}, 32'd0);
        chk("postreset_count", 32'(dut.count), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
